// File: rtl/usb_tx_sequencer_if.sv
// Handshake bundle between the packet source, payload buffer, serializer and the sequencer.
// master is the surrounding system side; slave is the sequencer.
interface usb_tx_sequencer_if;
  logic       pkt_start;
  logic [3:0] pkt_pid;
  logic       pkt_has_data;
  logic [6:0] pkt_len;
  logic       pkt_ready;
  logic       pkt_done;
  logic       pkt_err;
  logic [7:0] pld_data;
  logic       pld_valid;
  logic       pld_ready;
  logic [7:0] ser_byte;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;
  logic       eop_req;

  modport master (
    output pkt_start, pkt_pid, pkt_has_data, pkt_len, pld_data, pld_valid, ser_ready, ser_last,
    input  pkt_ready, pkt_done, pkt_err, pld_ready, ser_byte, ser_valid, eop_req
  );

  modport slave (
    input  pkt_start, pkt_pid, pkt_has_data, pkt_len, pld_data, pld_valid, ser_ready, ser_last,
    output pkt_ready, pkt_done, pkt_err, pld_ready, ser_byte, ser_valid, eop_req
  );
endinterface

// File: rtl/usb_tx_sequencer.sv
// USB packet transmit sequencer: feeds SYNC, PID, payload and CRC16 to a byte serializer,
// waits for the last bit to leave, requests EOP and enforces the inter-packet gap.
module usb_tx_sequencer #(
  parameter int MAX_PAYLOAD = 64,
  parameter int IFG_CYCLES  = 4
) (
  input logic               clk,
  input logic               rst,
  usb_tx_sequencer_if.slave bus
);
  typedef enum logic [3:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, DRAIN, EOP, GAP} state_t;

  localparam logic [6:0] LEN_MAX  = 7'(MAX_PAYLOAD);
  localparam logic [7:0] GAP_LAST = 8'(IFG_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  pid;
  logic        has_data;
  logic [6:0]  len;
  logic [6:0]  byte_cnt;
  logic [15:0] crc;
  logic [7:0]  last_cnt;
  logic [7:0]  last_total;
  logic [7:0]  gap_cnt;
  logic [7:0]  gap_next;
  logic        err_q, done_q, eop_q;
  logic        accept, reject, pld_xfer, in_packet;
  logic [7:0]  ser_byte;
  logic        ser_valid, pld_ready, pkt_ready;

  // CRC-16/USB register update for one byte, bits consumed LSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  // SYNC and PID always go out; data packets add payload plus two CRC bytes.
  assign last_total = has_data ? (8'd4 + {1'b0, len}) : 8'd2;
  assign gap_next   = (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
  assign in_packet  = state inside {SYNC, PID, DATA, CRC_LO, CRC_HI, DRAIN};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ser_byte   = 8'h00;
    ser_valid  = 1'b0;
    pld_ready  = 1'b0;
    pkt_ready  = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    pld_xfer   = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          pkt_ready = 1'b1;
          if (bus.pkt_start) begin
            if (bus.pkt_has_data && (bus.pkt_len > LEN_MAX)) begin
              reject = 1'b1;
            end else begin
              accept     = 1'b1;
              state_next = SYNC;
            end
          end
        end
        SYNC: begin
          ser_byte  = 8'h80;
          ser_valid = 1'b1;
          if (bus.ser_ready) state_next = PID;
        end
        PID: begin
          ser_byte  = {~pid, pid};
          ser_valid = 1'b1;
          if (bus.ser_ready) begin
            if (!has_data)        state_next = DRAIN;
            else if (len == 7'd0) state_next = CRC_LO;
            else                  state_next = DATA;
          end
        end
        DATA: begin
          ser_byte  = bus.pld_data;
          ser_valid = bus.pld_valid;
          pld_ready = bus.ser_ready;
          pld_xfer  = bus.pld_valid & bus.ser_ready;
          if (pld_xfer && (byte_cnt + 7'd1 == len)) state_next = CRC_LO;
        end
        CRC_LO: begin
          ser_byte  = ~crc[7:0];
          ser_valid = 1'b1;
          if (bus.ser_ready) state_next = CRC_HI;
        end
        CRC_HI: begin
          ser_byte  = ~crc[15:8];
          ser_valid = 1'b1;
          if (bus.ser_ready) state_next = DRAIN;
        end
        DRAIN: if (last_cnt == last_total) state_next = EOP;
        EOP:   state_next = GAP;
        GAP:   if (gap_cnt == GAP_LAST) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Request latching, payload CRC, ser_last accounting and the registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pid      <= '0;
      has_data <= 1'b0;
      len      <= '0;
      byte_cnt <= '0;
      crc      <= 16'hFFFF;
      last_cnt <= '0;
      gap_cnt  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      err_q   <= reject;
      eop_q   <= (state_next == EOP);
      done_q  <= (state_next == GAP) && (gap_next == GAP_LAST);
      gap_cnt <= gap_next;
      if (accept) begin
        pid      <= bus.pkt_pid;
        has_data <= bus.pkt_has_data;
        len      <= bus.pkt_len;
        byte_cnt <= '0;
        crc      <= 16'hFFFF;
        last_cnt <= '0;
      end else begin
        if (pld_xfer) begin
          byte_cnt <= byte_cnt + 7'd1;
          crc      <= crc16_step(crc, bus.pld_data);
        end
        if (in_packet && bus.ser_last && (last_cnt != 8'hFF)) last_cnt <= last_cnt + 8'd1;
      end
    end
  end

  assign bus.pkt_ready = pkt_ready;
  assign bus.ser_byte  = ser_byte;
  assign bus.ser_valid = ser_valid;
  assign bus.pld_ready = pld_ready;
  assign bus.pkt_err   = err_q & ~rst;
  assign bus.pkt_done  = done_q & ~rst;
  assign bus.eop_req   = eop_q & ~rst;
endmodule
